// File: rtl/change_capture_pkg.sv
// Shared defaults, FSM state encoding and record layout for the change-capture block.
package change_capture_pkg;

  localparam int unsigned ProbeWDef = 4;
  localparam int unsigned TsWDef    = 16;
  localparam int unsigned DepthDef  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSnapshot,
    StCapture
  } state_e;

  // Record as it appears on rd_data at default widths: ts in the MSBs.
  typedef struct packed {
    logic [TsWDef-1:0]    ts;
    logic [ProbeWDef-1:0] value;
    logic [ProbeWDef-1:0] changed;
  } rec_t;

endpackage

// File: rtl/change_capture_if.sv
// Record read port: FWFT valid/ready handshake carrying one {ts, value, changed} record.
interface change_capture_if
  import change_capture_pkg::*;
#(
  parameter int unsigned DataW = TsWDef + 2 * ProbeWDef
) ();

  logic             rd_valid;
  logic             rd_ready;
  logic [DataW-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/change_fifo.sv
// First-word-fall-through record FIFO with synchronous flush; Depth must be a power of two.
module change_fifo
  import change_capture_pkg::*;
#(
  parameter int unsigned Width = TsWDef + 2 * ProbeWDef,
  parameter int unsigned Depth = DepthDef
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok, wr_en;

  assign full_o     = (count_q == CntW'(Depth));
  assign empty_o    = (count_q == '0);
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop_i & ~empty_o;
    // A pop frees a slot in the same edge, so a full FIFO still accepts a push.
    push_ok  = push_i & (~full_o | pop_ok);
    wr_en    = push_ok & ~clr_i;
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
    count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/change_capture.sv
// Probe change recorder: snapshots the masked probes, then logs timestamped edges into a FIFO.
module change_capture
  import change_capture_pkg::*;
#(
  parameter int unsigned PROBE_W = ProbeWDef,
  parameter int unsigned TS_W    = TsWDef,
  parameter int unsigned DEPTH   = DepthDef
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PROBE_W-1:0] probe,
  input  logic [PROBE_W-1:0] probe_mask,
  input  logic               capture_en,
  input  logic               clear,
  change_capture_if.master   rd,
  output logic               overflow,
  output logic               ts_wrapped,
  output logic [7:0]         drop_count
);

  localparam int unsigned RecW = TS_W + 2 * PROBE_W;

  state_e             state_q, state_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [PROBE_W-1:0] prev_q, prev_d;
  logic               overflow_q, overflow_d;
  logic               wrapped_q, wrapped_d;
  logic [7:0]         drop_q, drop_d;
  logic [PROBE_W-1:0] masked, changed;
  logic               push, fifo_full, fifo_empty;
  logic [RecW-1:0]    push_data, fifo_rdata;

  assign masked  = probe & probe_mask;
  assign changed = (probe ^ prev_q) & probe_mask;

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    prev_d     = prev_q;
    overflow_d = overflow_q;
    wrapped_d  = wrapped_q;
    drop_d     = drop_q;
    push       = 1'b0;
    push_data  = '0;

    unique case (state_q)
      StIdle: begin
        ts_d = '0;
        if (capture_en) state_d = StSnapshot;
      end
      StSnapshot: begin
        if (capture_en) begin
          push      = 1'b1;
          push_data = {TS_W'(0), masked, probe_mask};
          prev_d    = probe;
          wrapped_d = 1'b0;
          // The first CAPTURE cycle is one cycle after the snapshot.
          ts_d      = TS_W'(1);
          state_d   = StCapture;
        end else begin
          state_d = StIdle;
        end
      end
      StCapture: begin
        if (capture_en) begin
          push      = |changed;
          push_data = {ts_q, masked, changed};
          prev_d    = probe;
          ts_d      = ts_q + TS_W'(1);
          if (ts_q == {TS_W{1'b1}}) wrapped_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (push && fifo_full && !rd.rd_ready) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    if (clear) begin
      state_d    = StIdle;
      ts_d       = '0;
      prev_d     = '0;
      overflow_d = 1'b0;
      wrapped_d  = 1'b0;
      drop_d     = '0;
      push       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ts_q       <= '0;
      prev_q     <= '0;
      overflow_q <= 1'b0;
      wrapped_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
      wrapped_q  <= wrapped_d;
      drop_q     <= drop_d;
    end
  end

  change_fifo #(
    .Width (RecW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .clr_i       (clear),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (rd.rd_ready),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rd.rd_valid = ~fifo_empty;
  assign rd.rd_data  = fifo_rdata;
  assign overflow    = overflow_q;
  assign ts_wrapped  = wrapped_q;
  assign drop_count  = drop_q;

endmodule
